// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions, serializer state encoding and divisor width.
package uart_pkg;

   localparam int DIV_W = 16;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVERRUN = 3;
   localparam int STAT_CNT_LSB = 8;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   // A programmed divisor of zero behaves as one clock per bit.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

endpackage

// File: rtl/uart_tx_wb_if.sv
// Wishbone classic bus bundle between the interconnect (master) and the
// UART transmitter (slave).
interface uart_tx_wb_if;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic [31:0] adr_i;
   logic        we_i;
   logic [3:0]  sel_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;

   modport master (
      output dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for TX bytes; dout shows the head entry combinationally
// whenever the FIFO is not empty. Full/empty are judged on registered count.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone classic UART transmitter: TXDATA/STATUS/DIVISOR registers, a TX
// FIFO and an 8N1 serializer. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_wb
   import uart_pkg::*;
#(
   parameter logic [31:0]      BASE_ADDR  = 32'h0002_0000,
   parameter int               FIFO_DEPTH = 16,
   parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
   input  logic        clk_i,
   input  logic        rst_i,
   uart_tx_wb_if.slave bus,
   output logic        txd_o,
   output logic        irq_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              ack_reg;
   logic [31:0]       dat_o_reg;
   logic              overrun_reg;
   logic [DIV_W-1:0]  div_reg;
   logic              par_en_cfg;
   logic              par_odd_cfg;

   logic              hit;
   logic              accept;
   logic              wr;
   logic [1:0]        offset;
   logic [31:0]       rd_data;
   logic              fifo_push;
   logic              fifo_pop;
   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              overrun_set;
   logic              overrun_clr;
   logic              unused_bits;

   tx_state_t         state_reg, state_next;
   logic [DIV_W-1:0]  baud_reg, baud_next;
   logic [DIV_W-1:0]  bit_reg, bit_next;
   logic [7:0]        shreg_reg, shreg_next;
   logic [DIV_W-1:0]  div_lat_reg, div_lat_next;
   logic              par_en_lat_reg, par_en_lat_next;
   logic              par_bit_reg, par_bit_next;
   logic              txd_reg, txd_next;
   logic              baud_done;

   assign hit    = (bus.adr_i[31:4] == BASE_ADDR[31:4]);
   assign accept = bus.cyc_i & bus.stb_i & ~ack_reg & hit;
   assign wr     = accept & bus.we_i;
   assign offset = bus.adr_i[3:2];

   assign fifo_push   = wr & (offset == REG_TXDATA) & bus.sel_i[0];
   assign overrun_set = fifo_push & fifo_full;
   assign overrun_clr = wr & (offset == REG_STATUS) & bus.dat_i[3];

   assign unused_bits = ^{bus.adr_i[1:0], bus.dat_i[31:16], bus.sel_i[3:2]};

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.dat_i[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      rd_data = '0;
      case (offset)
         REG_STATUS: begin
            rd_data[STAT_BUSY]              = (state_reg != TX_IDLE);
            rd_data[STAT_FULL]              = fifo_full;
            rd_data[STAT_EMPTY]             = fifo_empty;
            rd_data[STAT_OVERRUN]           = overrun_reg;
            rd_data[STAT_CNT_LSB +: 8]      = 8'(fifo_count);
         end
         REG_DIVISOR: begin
            rd_data[DIV_W-1:0] = div_reg;
            rd_data[17]        = par_en_cfg;
            rd_data[16]        = par_odd_cfg;
         end
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_reg     <= 1'b0;
         dat_o_reg   <= '0;
         overrun_reg <= 1'b0;
         div_reg     <= DIV_RESET;
      end else begin
         ack_reg <= accept;
         if (accept) begin
            dat_o_reg <= rd_data;
         end
         // A dropped push wins over a same-edge clear.
         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end else if (overrun_clr) begin
            overrun_reg <= 1'b0;
         end
         if (wr && offset == REG_DIVISOR) begin
            if (bus.sel_i[0]) div_reg[7:0]  <= bus.dat_i[7:0];
            if (bus.sel_i[1]) div_reg[15:8] <= bus.dat_i[15:8];
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   logic par_en_reg;
   logic par_odd_reg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         par_en_reg  <= 1'b0;
         par_odd_reg <= 1'b0;
      end else if (wr && offset == REG_DIVISOR && bus.sel_i[2]) begin
         par_en_reg  <= bus.dat_i[17];
         par_odd_reg <= bus.dat_i[16];
      end
   end

   assign par_en_cfg  = par_en_reg;
   assign par_odd_cfg = par_odd_reg;
`else
   assign par_en_cfg  = 1'b0;
   assign par_odd_cfg = 1'b0;
`endif

   assign bus.ack_o = ack_reg;
   assign bus.dat_o = dat_o_reg;

   // Serializer
   assign baud_done = (baud_reg == (div_lat_reg - DIV_W'(1)));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg      <= TX_IDLE;
         baud_reg       <= '0;
         bit_reg        <= '0;
         shreg_reg      <= '0;
         div_lat_reg    <= DIV_W'(1);
         par_en_lat_reg <= 1'b0;
         par_bit_reg    <= 1'b0;
         txd_reg        <= 1'b1;
      end else begin
         state_reg      <= state_next;
         baud_reg       <= baud_next;
         bit_reg        <= bit_next;
         shreg_reg      <= shreg_next;
         div_lat_reg    <= div_lat_next;
         par_en_lat_reg <= par_en_lat_next;
         par_bit_reg    <= par_bit_next;
         txd_reg        <= txd_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      baud_next       = baud_reg;
      bit_next        = bit_reg;
      shreg_next      = shreg_reg;
      div_lat_next    = div_lat_reg;
      par_en_lat_next = par_en_lat_reg;
      par_bit_next    = par_bit_reg;
      txd_next        = txd_reg;
      fifo_pop        = 1'b0;

      case (state_reg)
         TX_IDLE: begin
            txd_next = 1'b1;
            // Frame settings are captured here so mid-frame writes only affect the next byte.
            if (!fifo_empty) begin
               fifo_pop        = 1'b1;
               shreg_next      = fifo_dout;
               div_lat_next    = eff_div(div_reg);
               par_en_lat_next = par_en_cfg;
               par_bit_next    = (^fifo_dout) ^ par_odd_cfg;
               baud_next       = '0;
               state_next      = TX_START;
               txd_next        = 1'b0;
            end
         end
         TX_START: begin
            if (baud_done) begin
               baud_next  = '0;
               bit_next   = '0;
               txd_next   = shreg_reg[0];
               state_next = TX_DATA;
            end else begin
               baud_next = baud_reg + DIV_W'(1);
            end
         end
         TX_DATA: begin
            if (baud_done) begin
               baud_next = '0;
               if (bit_reg == DIV_W'(7)) begin
                  if (par_en_lat_reg) begin
                     state_next = TX_PARITY;
                     txd_next   = par_bit_reg;
                  end else begin
                     state_next = TX_STOP;
                     txd_next   = 1'b1;
                  end
               end else begin
                  bit_next   = bit_reg + DIV_W'(1);
                  shreg_next = {1'b0, shreg_reg[7:1]};
                  txd_next   = shreg_reg[1];
               end
            end else begin
               baud_next = baud_reg + DIV_W'(1);
            end
         end
         TX_PARITY: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = TX_STOP;
               txd_next   = 1'b1;
            end else begin
               baud_next = baud_reg + DIV_W'(1);
            end
         end
         TX_STOP: begin
            txd_next = 1'b1;
            if (baud_done) begin
               baud_next  = '0;
               state_next = TX_IDLE;
            end else begin
               baud_next = baud_reg + DIV_W'(1);
            end
         end
         default: begin
            state_next = TX_IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   assign txd_o = txd_reg;
   assign irq_o = fifo_empty & (state_reg == TX_IDLE);

endmodule

// File: tb/tb_uart_tx_wb.sv
// Scoreboard bench for uart_tx_wb: bus reads and serial frames are queued as
// expectations by the stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_uart_tx_wb;

   localparam logic [31:0] BASE = 32'h0002_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic txd;
   logic irq;
   bit   mon_en = 1'b1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_wb_if bus();

   uart_tx_wb #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (16),
      .DIV_RESET  (16'd434)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus),
      .txd_o (txd),
      .irq_o (irq)
   );

   typedef struct {
      logic        is_read;
      logic [31:0] exp;
   } bus_exp_t;

   typedef struct {
      logic [7:0] data;
      int         div;
      logic       par_en;
      logic       par_bit;
   } frame_t;

   bus_exp_t bus_q[$];
   string    bus_name_q[$];
   frame_t   tx_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input int div, input logic pe, input logic pb);
      frame_t f;
      f.data = d; f.div = div; f.par_en = pe; f.par_bit = pb;
      tx_q.push_back(f);
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] dat,
                          input logic [31:0] exp, input string nm);
      bus_exp_t e;
      bit got;
      e.is_read = ~we;
      e.exp     = exp;
      bus_q.push_back(e);
      bus_name_q.push_back(nm);
      @(negedge clk);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.adr_i = BASE + {28'd0, off};
      bus.dat_i = dat;
      bus.sel_i = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack_o) begin
            got = 1'b1;
            break;
         end
      end
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_ack actual=no_ack required=ack_within_8_cycles", nm);
         void'(bus_q.pop_back());
         void'(bus_name_q.pop_back());
      end
   endtask

   task automatic wb_write(input logic [3:0] off, input logic [31:0] dat, input string nm);
      wb_xfer(1'b1, off, dat, 32'h0, nm);
   endtask

   task automatic wb_read(input logic [3:0] off, input logic [31:0] exp, input string nm);
      wb_xfer(1'b0, off, 32'h0, exp, nm);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      for (int i = 0; i < budget && !(irq === 1'b1 && tx_q.size() == 0); i++) begin
         @(posedge clk);
         #1;
      end
      check(nm, {31'd0, irq}, 32'd1);
   endtask

   task automatic irq_latency(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (irq) begin
            n = i;
            break;
         end
      end
   endtask

   // Bus monitor: one expectation per acknowledged access.
   initial begin
      bus_exp_t e;
      string    nm;
      logic     ack_prev;
      ack_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.ack_o === 1'b1) begin
            check("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
            if (bus_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack actual=ack required=no_ack adr=0x%08h", bus.adr_i);
            end else begin
               e  = bus_q.pop_front();
               nm = bus_name_q.pop_front();
               if (e.is_read) begin
                  $display("bus read  %s dat_o=0x%08h", nm, bus.dat_o);
                  check(nm, bus.dat_o, e.exp);
               end else begin
                  $display("bus write %s acked", nm);
               end
            end
         end
         ack_prev = bus.ack_o;
      end
   end

   // Serial monitor: every frame bit must hold its level for exactly div samples.
   initial begin
      frame_t     f;
      logic [10:0] lv;
      int         nbits;
      bit         ok;
      bit         aborted;
      logic       bad_val;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && txd === 1'b0) begin
            if (tx_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame actual=start_bit required=idle_line");
               for (int k = 0; k < 5000 && txd === 1'b0; k++) @(negedge clk);
            end else begin
               f = tx_q.pop_front();
               nbits = f.par_en ? 11 : 10;
               lv = '1;
               lv[0] = 1'b0;
               for (int b = 0; b < 8; b++) lv[b+1] = f.data[b];
               if (f.par_en) lv[9] = f.par_bit;
               aborted = 1'b0;
               for (int b = 0; b < nbits; b++) begin
                  ok = 1'b1;
                  bad_val = lv[b];
                  for (int s = 0; s < f.div; s++) begin
                     if (b != 0 || s != 0) @(negedge clk);
                     if (!mon_en || !rst_n) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (txd !== lv[b]) begin
                        ok = 1'b0;
                        bad_val = txd;
                     end
                  end
                  if (aborted) break;
                  checks++;
                  if (!ok) begin
                     failures++;
                     $display("FAIL frame_%02h_bit%0d actual=%b required=%b for %0d clocks",
                              f.data, b, bad_val, lv[b], f.div);
                  end
               end
               $display("tx frame data=0x%02h div=%0d bits=%0d%s", f.data, f.div, nbits,
                        aborted ? " aborted" : "");
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int lows;
      logic [7:0] d;

      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.adr_i = '0;
      bus.dat_i = '0;
      bus.sel_i = '0;

      // Reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd1);
      check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
      check("rst_dat_o", bus.dat_o, 32'h0);
      rst_n = 1'b1;

      wb_read(4'h4, 32'h0000_0004, "status_after_reset");
      wb_read(4'h8, 32'h0000_01B2, "divisor_reset");
      wb_read(4'hC, 32'h0, "reg3_read");
      wb_read(4'h0, 32'h0, "txdata_read");

      // Near-miss address must not be acknowledged.
      @(negedge clk);
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
      bus.adr_i = BASE + 32'h14; bus.sel_i = 4'hF;
      n = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.ack_o) n++;
      end
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      check("nondecoded_no_ack", n, 0);

      // Basic frame A5 at 4 clocks per bit.
`ifdef UART_TX_PARITY_EN
      wb_write(4'h8, 32'h0000_0004, "divisor_4");
`else
      wb_write(4'h8, 32'hFFFF_0004, "divisor_4_upper_ignored");
`endif
      wb_read(4'h8, 32'h0000_0004, "divisor_readback_4");
      expect_frame(8'hA5, 4, 1'b0, 1'b0);
      wb_write(4'h0, 32'h0000_00A5, "txdata_a5");
      check("txd_high_at_ack", {31'd0, txd}, 32'd1);
      @(posedge clk);
      #1;
      check("txd_fall_after_ack", {31'd0, txd}, 32'd0);
      check("irq_low_in_frame", {31'd0, irq}, 32'd0);
      irq_latency(200, n);
      check("irq_after_40_clocks", n, 40);
      wb_read(4'h4, 32'h0000_0004, "status_idle_after_a5");

      // DIVISOR=0 runs at one clock per bit.
      wb_write(4'h8, 32'h0, "divisor_0");
      expect_frame(8'h3C, 1, 1'b0, 1'b0);
      wb_write(4'h0, 32'h0000_003C, "txdata_3c");
      wait_idle(200, "idle_after_div0");

      // Divisor change mid-frame only affects the following frame.
      wb_write(4'h8, 32'h0000_0008, "divisor_8");
      expect_frame(8'h96, 8, 1'b0, 1'b0);
      wb_write(4'h0, 32'h0000_0096, "txdata_96");
      wb_write(4'h8, 32'h0000_0003, "divisor_3_midframe");
      expect_frame(8'h5A, 3, 1'b0, 1'b0);
      wb_write(4'h0, 32'h0000_005A, "txdata_5a");
      wb_read(4'h8, 32'h0000_0003, "divisor_readback_3");
      wait_idle(400, "idle_after_midframe");

      // Fill the FIFO behind an in-flight byte, then overrun it.
      wb_write(4'h8, 32'h0000_0010, "divisor_16");
      expect_frame(8'h81, 16, 1'b0, 1'b0);
      wb_write(4'h0, 32'h0000_0081, "txdata_81");
      for (int i = 0; i < 17; i++) begin
         d = 8'h10 + 8'(i);
         if (i < 16) expect_frame(d, 16, 1'b0, 1'b0);
         wb_write(4'h0, {24'd0, d}, (i < 16) ? "txdata_fill" : "txdata_overrun");
      end
      wb_read(4'h4, 32'h0000_100B, "status_full_overrun");
      wb_write(4'h4, 32'h0000_0008, "status_clear_overrun");
      wb_read(4'h4, 32'h0000_1003, "status_full_cleared");
      wait_idle(4000, "idle_after_burst");
      wb_read(4'h4, 32'h0000_0004, "status_drained");

      // Asynchronous reset in the middle of a data bit.
      wb_write(4'h8, 32'h0000_0014, "divisor_20");
      mon_en = 1'b0;
      wb_write(4'h0, 32'h0000_00F0, "txdata_f0");
      wb_write(4'h0, 32'h0000_000F, "txdata_0f");
      repeat (35) @(posedge clk);
      #1;
      check("txd_low_before_reset", {31'd0, txd}, 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check("txd_high_on_async_reset", {31'd0, txd}, 32'd1);
      check("irq_high_on_async_reset", {31'd0, irq}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      wb_read(4'h4, 32'h0000_0004, "status_after_midframe_reset");
      wb_read(4'h8, 32'h0000_01B2, "divisor_after_midframe_reset");
      lows = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (txd !== 1'b1) lows++;
      end
      check("no_residual_tx", lows, 0);

`ifdef UART_TX_PARITY_EN
      // Odd parity over 0x07 (three ones) gives parity bit 0; 11 bits x 4 clocks.
      wb_write(4'h8, 32'h0003_0004, "divisor_parity_odd");
      wb_read(4'h8, 32'h0003_0004, "divisor_readback_parity");
      expect_frame(8'h07, 4, 1'b1, 1'b0);
      wb_write(4'h0, 32'h0000_0007, "txdata_07_parity");
      @(posedge clk);
      #1;
      check("parity_txd_fall", {31'd0, txd}, 32'd0);
      irq_latency(200, n);
      check("parity_frame_44_clocks", n, 44);
`endif

      repeat (4) @(posedge clk);
      check("bus_queue_drained", bus_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
